// File: rtl/rename_ckpt.sv
// rename_ckpt: register renamer with map table, circular free list and branch checkpoints.
// Optional macro RENAME_FREE_BYPASS_EN hands a same-cycle freed preg to an allocation when the free list is empty.
module rename_ckpt #(
  parameter int NUM_AREG = 32,
  parameter int NUM_PREG = 128,
  parameter int NUM_CKPT = 4,
  parameter int TAG_W = 4,
  localparam int PW = $clog2(NUM_PREG),
  localparam int AW = $clog2(NUM_AREG),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic             wr_rd,
  input  logic             is_ckpt,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [PW-1:0]    ps1,
  output logic [PW-1:0]    ps2,
  output logic [PW-1:0]    pd_new,
  output logic [PW-1:0]    pd_old,
  output logic [TAG_W-1:0] rob_tag,
  output logic [CW-1:0]    ckpt_id,
  output logic             is_ckpt_out,
  input  logic             free_valid,
  input  logic [PW-1:0]    free_preg,
  input  logic             res_valid,
  input  logic [CW-1:0]    res_id,
  input  logic             res_mispredict
);
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
  localparam int FW = $clog2(FL_DEPTH);

  logic [PW-1:0] map [NUM_AREG];
  logic [PW-1:0] fl [FL_DEPTH];
  logic [FW:0] rd_ptr, wr_ptr, rd_nxt;
  logic [TAG_W-1:0] tag_cnt;
  logic [PW-1:0] ck_map [NUM_CKPT][NUM_AREG];
  logic [FW:0] ck_rd [NUM_CKPT];
  logic [TAG_W-1:0] ck_tag [NUM_CKPT];
  logic [NUM_CKPT-1:0] ck_valid, ck_valid_nxt;
  logic [CW-1:0] tail, dist_t, dist_i;
  logic alloc, fl_empty, free_ok, bypass, accept, mis, pop, push;
  logic [PW-1:0] pd_alloc;

  // Pointer = {wrap, index}; the index wraps at FL_DEPTH, which need not be a power of two.
  function automatic logic [FW:0] inc(input logic [FW:0] p);
    return (p[FW-1:0] == FW'(FL_DEPTH - 1)) ? {~p[FW], FW'(0)} : p + 1'b1;
  endfunction

  assign alloc = wr_rd && rd != '0;
  assign fl_empty = rd_ptr == wr_ptr;
  assign free_ok = free_valid && free_preg != '0;
`ifdef RENAME_FREE_BYPASS_EN
  assign bypass = alloc && fl_empty && free_ok;
`else
  assign bypass = 1'b0;
`endif
  assign mis = res_valid && res_mispredict && ck_valid[res_id];
  assign ready_in = !reset && (ready_out || !valid_out) && !(alloc && fl_empty && !bypass) &&
                    !(is_ckpt && ck_valid[tail]) && !(res_valid && res_mispredict);
  assign accept = valid_in && ready_in;
  assign pop = accept && alloc && !bypass;
  assign push = free_ok && !(accept && bypass);
  assign pd_alloc = bypass ? free_preg : fl[rd_ptr[FW-1:0]];
  assign rd_nxt = pop ? inc(rd_ptr) : rd_ptr;
  assign dist_t = tail - res_id;

  // A mispredict squashes every slot from res_id up to tail-1; distance 0 means the ring is full.
  always_comb begin
    ck_valid_nxt = ck_valid;
    dist_i = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      dist_i = CW'(i) - res_id;
      if (res_valid && ck_valid[res_id] &&
          (res_mispredict ? (dist_i < dist_t || dist_t == '0) : dist_i == '0))
        ck_valid_nxt[i] = 1'b0;
    end
    if (accept && is_ckpt) ck_valid_nxt[tail] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) map[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PW'(NUM_AREG + i);
      rd_ptr <= '0;
      wr_ptr <= {1'b1, FW'(0)};
      tag_cnt <= '0;
      ck_valid <= '0;
      tail <= '0;
    end else begin
      for (int i = 0; i < NUM_AREG; i++)
        map[i] <= mis ? ck_map[res_id][i] : (accept && alloc && rd == AW'(i)) ? pd_alloc : map[i];
      rd_ptr <= mis ? ck_rd[res_id] : rd_nxt;
      if (push) begin
        fl[wr_ptr[FW-1:0]] <= free_preg;
        wr_ptr <= inc(wr_ptr);
      end
      tag_cnt <= mis ? ck_tag[res_id] + 1'b1 : accept ? tag_cnt + 1'b1 : tag_cnt;
      ck_valid <= ck_valid_nxt;
      tail <= mis ? res_id + 1'b1 : (accept && is_ckpt) ? tail + 1'b1 : tail;
    end
  end

  // Snapshot includes the branch's own destination update and its own pop.
  always_ff @(posedge clk) begin
    if (accept && is_ckpt) begin
      for (int i = 0; i < NUM_AREG; i++)
        ck_map[tail][i] <= (alloc && rd == AW'(i)) ? pd_alloc : map[i];
      ck_rd[tail] <= rd_nxt;
      ck_tag[tail] <= tag_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      ps1 <= '0;
      ps2 <= '0;
      pd_new <= '0;
      pd_old <= '0;
      rob_tag <= '0;
      ckpt_id <= '0;
      is_ckpt_out <= 1'b0;
    end else if (mis) begin
      valid_out <= 1'b0;
    end else if (accept) begin
      valid_out <= 1'b1;
      ps1 <= map[rs1];
      ps2 <= map[rs2];
      pd_old <= map[rd];
      pd_new <= alloc ? pd_alloc : '0;
      rob_tag <= tag_cnt;
      ckpt_id <= tail;
      is_ckpt_out <= is_ckpt;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rename_ckpt.sv
// tb_rename_ckpt: scoreboard bench for rename_ckpt; expected outputs come from a history-based free-list model.
module tb_rename_ckpt;
  logic clk = 0, reset = 1, valid_in = 0, ready_in, wr_rd = 0, is_ckpt = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic valid_out, ready_out = 1, is_ckpt_out;
  logic [6:0] ps1, ps2, pd_new, pd_old, free_preg = 0;
  logic [3:0] rob_tag;
  logic [1:0] ckpt_id, res_id = 0;
  logic free_valid = 0, res_valid = 0, res_mispredict = 0;

  rename_ckpt dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wr_rd(wr_rd), .is_ckpt(is_ckpt),
    .valid_out(valid_out), .ready_out(ready_out),
    .ps1(ps1), .ps2(ps2), .pd_new(pd_new), .pd_old(pd_old),
    .rob_tag(rob_tag), .ckpt_id(ckpt_id), .is_ckpt_out(is_ckpt_out),
    .free_valid(free_valid), .free_preg(free_preg),
    .res_valid(res_valid), .res_id(res_id), .res_mispredict(res_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] ps1, ps2, pd_new, pd_old;
    logic [3:0] tag;
    logic ck;
    logic [1:0] cid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;
  logic [6:0] mmap [32];
  logic [6:0] fl_hist[$];
  int rd_abs;
  logic [3:0] mtag;
  logic [1:0] mtail;
  logic [6:0] ck_map [4][32];
  int ck_rd [4];
  logic [3:0] ck_tag [4];
  bit ck_v [4];

  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got ps1=%0d pd_new=%0d tag=%0d with empty scoreboard", ps1, pd_new, rob_tag);
      end else begin
        mon_e = sb.pop_front();
        if (ps1 !== mon_e.ps1 || ps2 !== mon_e.ps2 || pd_new !== mon_e.pd_new || pd_old !== mon_e.pd_old ||
            rob_tag !== mon_e.tag || is_ckpt_out !== mon_e.ck || (mon_e.ck && ckpt_id !== mon_e.cid)) begin
          n_bad++;
          $display("FAIL out_item: got ps1=%0d ps2=%0d pd_new=%0d pd_old=%0d tag=%0d ck=%0b id=%0d, want ps1=%0d ps2=%0d pd_new=%0d pd_old=%0d tag=%0d ck=%0b id=%0d",
                   ps1, ps2, pd_new, pd_old, rob_tag, is_ckpt_out, ckpt_id,
                   mon_e.ps1, mon_e.ps2, mon_e.pd_new, mon_e.pd_old, mon_e.tag, mon_e.ck, mon_e.cid);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mmap[i] = 7'(i);
    fl_hist.delete();
    for (int i = 0; i < 96; i++) fl_hist.push_back(7'(32 + i));
    rd_abs = 0;
    mtag = 0;
    mtail = 0;
    for (int i = 0; i < 4; i++) ck_v[i] = 0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [4:0] a1, a2, d, input bit w, ck, fv, input logic [6:0] fp);
    exp_t e;
    bit al, byp;
    e.ps1 = mmap[a1];
    e.ps2 = mmap[a2];
    e.pd_old = mmap[d];
    e.tag = mtag;
    e.ck = ck;
    e.cid = mtail;
    e.pd_new = 0;
    al = w && d != 0;
    byp = 0;
`ifdef RENAME_FREE_BYPASS_EN
    byp = al && rd_abs == fl_hist.size() && fv && fp != 0;
`endif
    if (al) begin
      e.pd_new = byp ? fp : fl_hist[rd_abs];
      if (!byp) rd_abs++;
      mmap[d] = e.pd_new;
    end
    if (ck) begin
      for (int i = 0; i < 32; i++) ck_map[mtail][i] = mmap[i];
      ck_rd[mtail] = rd_abs;
      ck_tag[mtail] = mtag;
      ck_v[mtail] = 1;
      mtail = mtail + 1;
    end
    mtag = mtag + 1;
    if (fv && fp != 0 && !byp) fl_hist.push_back(fp);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1;
    valid_in = 0; wr_rd = 0; is_ckpt = 0; free_valid = 0; res_valid = 0; res_mispredict = 0;
    ready_out = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic send(input logic [4:0] a1, a2, d, input bit w, ck, input bit fv = 0, input logic [6:0] fp = 0);
    int t = 0;
    rs1 = a1; rs2 = a2; rd = d; wr_rd = w; is_ckpt = ck; valid_in = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_in && t < 100);
    if (!ready_in) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_in=%b after %0d cycles, want 1", ready_in, t);
      valid_in = 0;
      return;
    end
    free_valid = fv; free_preg = fp;
    @(posedge clk);
    #1;
    valid_in = 0; wr_rd = 0; is_ckpt = 0; free_valid = 0;
    model_accept(a1, a2, d, w, ck, fv, fp);
  endtask

  task automatic do_resolve(input logic [1:0] id, input bit m, input bit fv = 0, input logic [6:0] fp = 0);
    int j;
    res_valid = 1; res_id = id; res_mispredict = m; free_valid = fv; free_preg = fp;
    @(negedge clk);
    if (m) begin
      n_cmp++;
      if (ready_in !== 1'b0) begin
        n_bad++;
        $display("FAIL mispredict_blocks: ready_in=%b want 0", ready_in);
      end
    end
    @(posedge clk);
    #1;
    res_valid = 0; res_mispredict = 0; free_valid = 0;
    if (ck_v[id]) begin
      if (m) begin
        for (int i = 0; i < 32; i++) mmap[i] = ck_map[id][i];
        rd_abs = ck_rd[id];
        mtag = ck_tag[id] + 1;
        j = id;
        do begin
          ck_v[j] = 0;
          j = (j + 1) % 4;
        end while (j != int'(mtail));
        mtail = id + 1;
      end else ck_v[id] = 0;
    end
    if (fv && fp != 0) fl_hist.push_back(fp);
  endtask

  task automatic test_reset();
    reset = 1;
    valid_in = 0; wr_rd = 0; is_ckpt = 0; free_valid = 0; res_valid = 0; res_mispredict = 0;
    @(negedge clk);
    n_cmp++;
    if (ready_in !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready_low: ready_in=%b want 0", ready_in);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({valid_out, ps1, ps2, pd_new, pd_old, rob_tag, ckpt_id, is_ckpt_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid_out=%b ps1=%0d ps2=%0d pd_new=%0d pd_old=%0d tag=%0d want all 0",
               valid_out, ps1, ps2, pd_new, pd_old, rob_tag);
    end
    @(posedge clk);
    #1 reset = 0;
    ready_out = 1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_high: ready_in=%b want 1", ready_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    do_reset();
    send(1, 2, 5, 1, 0);
    send(5, 6, 6, 1, 0);
    send(6, 0, 6, 1, 0);
    send(3, 4, 0, 1, 0);
    send(0, 7, 7, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_freelist();
    do_reset();
    for (int i = 0; i < 96; i++) send(5'(i % 32), 0, 5'(i % 31 + 1), 1, 0);
    rs1 = 0; rs2 = 0; rd = 7; wr_rd = 1; is_ckpt = 0; valid_in = 1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ready_in !== 1'b0) begin
        n_bad++;
        $display("FAIL fl_empty_stall: ready_in=%b want 0", ready_in);
      end
    end
    free_valid = 1; free_preg = 5;
    #1;
`ifdef RENAME_FREE_BYPASS_EN
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_bypass_ready: ready_in=%b want 1", ready_in);
    end
    @(posedge clk);
    #1 valid_in = 0; wr_rd = 0; free_valid = 0;
    model_accept(0, 0, 7, 1, 0, 1, 5);
`else
    n_cmp++;
    if (ready_in !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_free_same_cycle: ready_in=%b want 0", ready_in);
    end
    @(posedge clk);
    #1 free_valid = 0;
    fl_hist.push_back(5);
    @(negedge clk);
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_after_free: ready_in=%b want 1", ready_in);
    end
    @(posedge clk);
    #1 valid_in = 0; wr_rd = 0;
    model_accept(0, 0, 7, 1, 0, 0, 0);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ckpt_mispredict();
    do_reset();
    send(0, 0, 1, 1, 0);
    send(0, 0, 2, 1, 0);
    send(0, 0, 3, 1, 0);
    send(1, 2, 0, 0, 1);
    send(0, 0, 7, 1, 0);
    do_resolve(0, 1);
    send(7, 0, 7, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ckpt_full();
    do_reset();
    repeat (4) send(0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      valid_in = 1; is_ckpt = 1; wr_rd = 0;
      @(negedge clk);
      n_cmp++;
      if (ready_in !== 1'b0) begin
        n_bad++;
        $display("FAIL ckpt_full_block%0d: ready_in=%b want 0", k, ready_in);
      end
      @(posedge clk);
      #1 valid_in = 0; is_ckpt = 0;
      if (k == 0) do_resolve(1, 0);
    end
    do_resolve(0, 0);
    send(0, 0, 0, 0, 1);
    do_resolve(1, 1);
    send(0, 0, 9, 1, 0);
    do_resolve(2, 1);
    send(0, 0, 9, 1, 0);
    send(9, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_jalr();
    do_reset();
    for (int i = 0; i < 18; i++) send(0, 0, 5'(i + 2), 1, 0);
    send(3, 0, 1, 1, 1);
    send(1, 0, 1, 1, 0);
    do_resolve(0, 1, 1, 7'd32);
    send(1, 0, 1, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] frees[$];
    logic [4:0] a1, a2, d;
    bit w;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      d = 5'($urandom_range(0, 31));
      w = 1'($urandom_range(0, 1));
      if (i % 3 == 2 && frees.size() > 0) send(a1, a2, d, w, 0, 1, frees.pop_front());
      else send(a1, a2, d, w, 0);
      if (w && d != 0) frees.push_back(sb[$].pd_old);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    ready_out = 0;
    send(1, 2, 3, 1, 0);
    rs1 = 0; rs2 = 0; rd = 4; wr_rd = 1; is_ckpt = 0; valid_in = 1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ready_in !== 1'b0 || valid_out !== 1'b1 || pd_new !== sb[0].pd_new || ps1 !== sb[0].ps1) begin
        n_bad++;
        $display("FAIL stall_hold: ready_in=%b valid_out=%b pd_new=%0d ps1=%0d, want 0 1 %0d %0d",
                 ready_in, valid_out, pd_new, ps1, sb[0].pd_new, sb[0].ps1);
      end
    end
    @(posedge clk);
    #1 valid_in = 0; wr_rd = 0; ready_out = 1;
    send(0, 0, 4, 1, 0);
    ready_out = 0;
    @(negedge clk);
    test_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_freelist();
    test_ckpt_mispredict();
    test_ckpt_full();
    test_jalr();
    test_back_to_back();
    test_stall();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d outputs still expected, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
